// File: rtl/sort_chute_scheduler.sv
// Package-scale sequencer: debounces the scale reading, classifies the package into one of
// six weight groups and pulses the matching chute gate, or the reject lane when that bin is full.
module sort_chute_scheduler #(
    parameter int unsigned STABLE_CYC = 4,
    parameter int unsigned GATE_CYC   = 8,
    parameter int unsigned BIN_CAP    = 200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] weight,
    input  logic [5:0]  bin_empty,
    output logic [5:0]  gate,
    output logic        divert,
    output logic        sorted,
    output logic [2:0]  grp,
    output logic        busy,
    output logic [5:0]  bin_full,
    output logic [7:0]  reject_cnt
);

    typedef enum logic [1:0] {IDLE, SETTLE, DISPATCH, WAIT_CLEAR} state_t;

    localparam logic [3:0] STAB_LAST = 4'(STABLE_CYC - 1);
    localparam logic [7:0] GATE_LAST = 8'(GATE_CYC);
    localparam logic [7:0] CAP       = 8'(BIN_CAP);

    state_t      state_q, state_d;
    logic [11:0] w_prev_q, w_prev_d;
    logic [3:0]  stab_cnt_q, stab_cnt_d;
    logic [7:0]  gate_cnt_q, gate_cnt_d;
    logic [5:0]  gate_q, gate_d;
    logic        divert_q, divert_d;
    logic        sorted_q, sorted_d;
    logic [2:0]  grp_q, grp_d;
    logic [7:0]  reject_cnt_q, reject_cnt_d;
    logic [7:0]  fill_q [6];
    logic [7:0]  fill_d [6];
    logic [5:0]  fill_inc;
    logic [2:0]  new_grp;
    logic [5:0]  grp_oh;

    function automatic logic [2:0] classify(input logic [11:0] w);
        if (w <= 12'd250)       return 3'd1;
        else if (w <= 12'd500)  return 3'd2;
        else if (w <= 12'd750)  return 3'd3;
        else if (w <= 12'd1500) return 3'd4;
        else if (w <= 12'd2000) return 3'd5;
        else                    return 3'd6;
    endfunction

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        state_d      = state_q;
        w_prev_d     = w_prev_q;
        stab_cnt_d   = stab_cnt_q;
        gate_cnt_d   = gate_cnt_q;
        gate_d       = gate_q;
        divert_d     = divert_q;
        sorted_d     = 1'b0;
        grp_d        = grp_q;
        reject_cnt_d = reject_cnt_q;
        fill_inc     = 6'd0;
        new_grp      = classify(weight);
        grp_oh       = 6'b1 << (new_grp - 3'd1);

        case (state_q)
            IDLE: begin
                if (weight != 12'd0) begin
                    state_d    = SETTLE;
                    w_prev_d   = weight;
                    stab_cnt_d = 4'd1;
                end
            end
            SETTLE: begin
                if (weight == 12'd0) begin
                    state_d = IDLE;
                end else if (weight != w_prev_q) begin
                    w_prev_d   = weight;
                    stab_cnt_d = 4'd1;
                end else if (stab_cnt_q == STAB_LAST) begin
                    // Full check sees the fill count as it stands before this package lands.
                    state_d    = DISPATCH;
                    grp_d      = new_grp;
                    sorted_d   = 1'b1;
                    gate_cnt_d = 8'd1;
                    if ((bin_full & grp_oh) != 6'd0) begin
                        divert_d = 1'b1;
                        if (reject_cnt_q != 8'hFF) reject_cnt_d = reject_cnt_q + 8'd1;
                    end else begin
                        gate_d   = grp_oh;
                        fill_inc = grp_oh;
                    end
                end else begin
                    stab_cnt_d = stab_cnt_q + 4'd1;
                end
            end
            DISPATCH: begin
                if (gate_cnt_q == GATE_LAST) begin
                    state_d  = WAIT_CLEAR;
                    gate_d   = 6'd0;
                    divert_d = 1'b0;
                end else begin
                    gate_cnt_d = gate_cnt_q + 8'd1;
                end
            end
            WAIT_CLEAR: begin
                if (weight == 12'd0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        for (int k = 0; k < 6; k++) begin
            if (bin_empty[k])
                fill_d[k] = fill_inc[k] ? 8'd1 : 8'd0;
            else if (fill_inc[k] && fill_q[k] != 8'hFF)
                fill_d[k] = fill_q[k] + 8'd1;
            else
                fill_d[k] = fill_q[k];
            bin_full[k] = (fill_q[k] >= CAP);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; the fill array is reset with the rest.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            w_prev_q     <= 12'd0;
            stab_cnt_q   <= 4'd0;
            gate_cnt_q   <= 8'd0;
            gate_q       <= 6'd0;
            divert_q     <= 1'b0;
            sorted_q     <= 1'b0;
            grp_q        <= 3'd0;
            reject_cnt_q <= 8'd0;
            for (int k = 0; k < 6; k++) fill_q[k] <= 8'd0;
        end else begin
            state_q      <= state_d;
            w_prev_q     <= w_prev_d;
            stab_cnt_q   <= stab_cnt_d;
            gate_cnt_q   <= gate_cnt_d;
            gate_q       <= gate_d;
            divert_q     <= divert_d;
            sorted_q     <= sorted_d;
            grp_q        <= grp_d;
            reject_cnt_q <= reject_cnt_d;
            for (int k = 0; k < 6; k++) fill_q[k] <= fill_d[k];
        end
    end

    assign gate       = gate_q;
    assign divert     = divert_q;
    assign sorted     = sorted_q;
    assign grp        = grp_q;
    assign reject_cnt = reject_cnt_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_sort_chute_scheduler.sv
// Bench for sort_chute_scheduler: directed scenarios plus random scale traffic, checked each
// cycle against a run-length / countdown model of the package flow.
module tb_sort_chute_scheduler;

    localparam int STABLE = 4;
    localparam int GATE   = 8;
    localparam int CAP    = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [11:0] weight = 12'd0;
    logic [5:0]  bin_empty = 6'd0;
    logic [5:0]  gate;
    logic        divert, sorted, busy;
    logic [2:0]  grp;
    logic [5:0]  bin_full;
    logic [7:0]  reject_cnt;

    sort_chute_scheduler #(.STABLE_CYC(STABLE), .GATE_CYC(GATE), .BIN_CAP(CAP)) dut (
        .clk(clk), .reset(reset), .weight(weight), .bin_empty(bin_empty),
        .gate(gate), .divert(divert), .sorted(sorted), .grp(grp), .busy(busy),
        .bin_full(bin_full), .reject_cnt(reject_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: run length of identical non-zero samples, gate countdown, re-arm on zero.
    int m_run, m_wlast, m_gate_left, m_grp, m_rej;
    bit m_need_zero, m_reject, m_sorted;
    int m_fill [6];

    int sc_gate_cycles, sc_sorted;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int group_of(input int w);
        int bounds [5] = '{250, 500, 750, 1500, 2000};
        int g = 1;
        foreach (bounds[i]) if (w > bounds[i]) g++;
        return g;
    endfunction

    task automatic model_reset();
        m_run = 0; m_wlast = 0; m_gate_left = 0; m_grp = 0; m_rej = 0;
        m_need_zero = 0; m_reject = 0; m_sorted = 0;
        foreach (m_fill[k]) m_fill[k] = 0;
    endtask

    task automatic model_edge(input int w, input logic [5:0] be);
        int inc = -1;
        m_sorted = 0;
        if (m_gate_left > 0) begin
            m_gate_left--;
            if (m_gate_left == 0) m_need_zero = 1;
        end else if (m_need_zero) begin
            if (w == 0) m_need_zero = 0;
        end else begin
            if (w == 0) m_run = 0;
            else if (m_run > 0 && w == m_wlast) m_run++;
            else m_run = 1;
            m_wlast = w;
            if (m_run == STABLE) begin
                m_grp = group_of(w);
                m_run = 0;
                m_gate_left = GATE;
                m_sorted = 1;
                if (m_fill[m_grp-1] >= CAP) begin
                    m_reject = 1;
                    if (m_rej < 255) m_rej++;
                end else begin
                    m_reject = 0;
                    inc = m_grp - 1;
                end
            end
        end
        for (int k = 0; k < 6; k++) begin
            if (be[k]) m_fill[k] = (inc == k) ? 1 : 0;
            else if (inc == k && m_fill[k] < 255) m_fill[k]++;
        end
    endtask

    task automatic compare_all();
        logic [5:0] eg, ef;
        eg = (m_gate_left > 0 && !m_reject) ? 6'(1 << (m_grp - 1)) : 6'd0;
        for (int k = 0; k < 6; k++) ef[k] = (m_fill[k] >= CAP);
        check("gate", 32'(gate), 32'(eg));
        check("divert", 32'(divert), 32'(m_gate_left > 0 && m_reject));
        check("sorted", 32'(sorted), 32'(m_sorted));
        check("grp", 32'(grp), 32'(m_grp));
        check("busy", 32'(busy), 32'(m_gate_left > 0 || m_need_zero || m_run > 0));
        check("bin_full", 32'(bin_full), 32'(ef));
        check("reject_cnt", 32'(reject_cnt), 32'(m_rej));
        if (gate != 6'd0) sc_gate_cycles++;
        if (sorted) sc_sorted++;
    endtask

    task automatic step(input int w, input logic [5:0] be);
        weight = 12'(w);
        bin_empty = be;
        @(posedge clk);
        model_edge(w, be);
        @(negedge clk);
        compare_all();
    endtask

    task automatic hold(input int w, input int n);
        for (int i = 0; i < n; i++) step(w, 6'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pick [12] = '{1, 250, 251, 500, 501, 750, 751, 1500, 1501, 2000, 2001, 4095};
        int gseen;
        model_reset();
        repeat (3) @(negedge clk);
        compare_all();
        reset = 1'b1;
        step(0, 6'd0);

        // Basic sort
        sc_gate_cycles = 0; sc_sorted = 0;
        hold(270, 12);
        hold(0, 3);
        check("basic_gate_cycles", 32'(sc_gate_cycles), 32'd8);
        check("basic_sorted_pulses", 32'(sc_sorted), 32'd1);

        // Debounce
        step(500, 6'd0);
        hold(501, 12);
        hold(0, 2);

        // Lift during settle
        sc_sorted = 0;
        hold(300, 2);
        hold(0, 3);
        check("lift_sorted", 32'(sc_sorted), 32'd0);

        // Bin full (BIN_CAP=2)
        for (int p = 0; p < 3; p++) begin
            hold(2100, 12);
            hold(0, 2);
        end
        check("binfull_flag5", 32'(bin_full[5]), 32'd1);
        check("binfull_rejects", 32'(reject_cnt), 32'd1);
        step(0, 6'b100000);
        check("binfull_cleared", 32'(bin_full[5]), 32'd0);

        // Package left on scale
        sc_gate_cycles = 0; sc_sorted = 0;
        hold(1013, 40);
        check("left_busy", 32'(busy), 32'd1);
        hold(0, 2);
        check("left_gate_cycles", 32'(sc_gate_cycles), 32'd8);
        check("left_sorted", 32'(sc_sorted), 32'd1);

        // Random traffic
        for (int s = 0; s < 400; s++) begin
            int w, len;
            logic [5:0] be;
            if ($urandom_range(2, 0) == 0) w = 0;
            else if ($urandom_range(1, 0) == 0) w = pick[$urandom_range(11, 0)];
            else w = $urandom_range(4095, 1);
            len = $urandom_range(12, 1);
            for (int i = 0; i < len; i++) begin
                for (int k = 0; k < 6; k++) be[k] = ($urandom_range(39, 0) == 0);
                step(w, be);
            end
        end

        // Reset mid-gate
        hold(0, 2);
        gseen = 0;
        for (int i = 0; i < 20 && gseen < 3; i++) begin
            step(1013, 6'd0);
            if (gate != 6'd0) gseen++;
        end
        check("midgate_reached", 32'(gseen), 32'd3);
        reset = 1'b0;
        #1;
        model_reset();
        check("rst_gate", 32'(gate), 32'd0);
        check("rst_divert", 32'(divert), 32'd0);
        check("rst_grp", 32'(grp), 32'd0);
        check("rst_reject", 32'(reject_cnt), 32'd0);
        check("rst_bin_full", 32'(bin_full), 32'd0);
        weight = 12'd0;
        @(negedge clk);
        reset = 1'b1;
        hold(0, 3);
        check("post_reset_idle", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
